// File: rtl/i2c_pkg.sv
// Shared types for the I2C register-interface target: FSM states, bus events,
// default glitch-filter length.
package i2c_pkg;

  localparam int unsigned FILTER_LEN_DEF = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_A_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } bus_ev_e;

  // START/STOP are SDA edges while the filtered SCL is high.
  function automatic bus_ev_e bus_event(input logic scl, input logic sda_rise, input logic sda_fall);
    if (scl && sda_fall) return EV_START;
    if (scl && sda_rise) return EV_STOP;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability filter for one open-drain bus line;
// emits the filtered level and single-cycle rise/fall pulses.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_accept;

  // A new level is accepted once it has differed for FILTER_LEN consecutive cycles.
  assign w_diff   = (r_sync[1] != r_filt);
  assign w_accept = w_diff && (r_cnt == CW'(FILTER_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '1;
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_rise <= w_accept && r_sync[1];
      r_fall <= w_accept && !r_sync[1];
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_filt;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target bridging bus transfers to a byte-wide register port with an
// auto-incrementing pointer; the first written byte sets the pointer.
module i2c_target_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen_o,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy_o,
  output logic       irq_o
);

  logic    w_scl, w_scl_rise, w_scl_fall;
  logic    w_sda, w_sda_rise, w_sda_fall;
  bus_ev_e w_ev;
  logic [7:0] w_byte;

  state_e     r_state,   w_state;
  logic [3:0] r_bitcnt,  w_bitcnt;
  logic [7:0] r_shift,   w_shift;
  logic       r_first,   w_first;
  logic       r_rw,      w_rw;
  logic       r_mack,    w_mack;
  logic       r_rdph,    w_rdph;
  logic       r_sda_oen, w_sda_oen;
  logic       r_busy,    w_busy;
  logic       r_irq,     w_irq;
  logic       r_we,      w_we;
  logic       r_re,      w_re;
  logic [7:0] r_addr,    w_addr;
  logic [7:0] r_wdata,   w_wdata;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_line (scl_i),
    .o_level(w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_line (sda_i),
    .o_level(w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_ev   = bus_event(w_scl, w_sda_rise, w_sda_fall);
  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_first   <= 1'b0;
      r_rw      <= 1'b0;
      r_mack    <= 1'b0;
      r_rdph    <= 1'b0;
      r_sda_oen <= 1'b0;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state;
      r_bitcnt  <= w_bitcnt;
      r_shift   <= w_shift;
      r_first   <= w_first;
      r_rw      <= w_rw;
      r_mack    <= w_mack;
      r_rdph    <= w_rdph;
      r_sda_oen <= w_sda_oen;
      r_busy    <= w_busy;
      r_irq     <= w_irq;
      r_we      <= w_we;
      r_re      <= w_re;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_bitcnt  = r_bitcnt;
    w_shift   = r_shift;
    w_first   = r_first;
    w_rw      = r_rw;
    w_mack    = r_mack;
    w_rdph    = r_rdph;
    w_sda_oen = r_sda_oen;
    w_busy    = r_busy;
    w_irq     = 1'b0;
    w_we      = 1'b0;
    w_re      = 1'b0;
    w_wdata   = r_wdata;
    // Pointer advances in the cycle after the write strobe is visible.
    w_addr    = r_we ? r_addr + 8'd1 : r_addr;

    if (w_ev == EV_STOP) begin
      w_state   = ST_IDLE;
      w_sda_oen = 1'b0;
      w_busy    = 1'b0;
      w_irq     = r_busy;
      w_rdph    = 1'b0;
    end else if (w_ev == EV_START) begin
      w_state   = ST_ADDR;
      w_bitcnt  = '0;
      w_sda_oen = 1'b0;
      w_busy    = 1'b0;
      w_rdph    = 1'b0;
    end else begin
      unique case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift  = w_byte;
            w_bitcnt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              if ((w_byte[7:1] == TARGET_ADDR) && (w_byte[7:1] != '0)) begin
                w_state = ST_A_ACK;
                w_busy  = 1'b1;
                w_rw    = w_byte[0];
              end else begin
                w_state = ST_IDLE;
              end
            end
          end
        end
        // ACK states: first SCL fall drives SDA low, second releases and moves on.
        ST_A_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oen) begin
              w_sda_oen = 1'b1;
            end else begin
              w_sda_oen = 1'b0;
              w_bitcnt  = '0;
              if (r_rw) begin
                w_state = ST_RD_LOAD;
              end else begin
                w_state = ST_WR_BYTE;
                w_first = 1'b1;
              end
            end
          end
        end
        ST_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift  = w_byte;
            w_bitcnt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              w_state = ST_WR_ACK;
              if (r_first) begin
                w_addr  = w_byte;
                w_first = 1'b0;
              end else begin
                w_wdata = w_byte;
                w_we    = 1'b1;
              end
            end
          end
        end
        ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oen) begin
              w_sda_oen = 1'b1;
            end else begin
              w_sda_oen = 1'b0;
              w_bitcnt  = '0;
              w_state   = ST_WR_BYTE;
            end
          end
        end
        // Phase 0 raises reg_re; read data is captured the cycle after the strobe.
        ST_RD_LOAD: begin
          if (!r_rdph) begin
            w_re   = 1'b1;
            w_rdph = 1'b1;
          end else if (!r_re) begin
            w_shift   = reg_rdata;
            w_sda_oen = ~reg_rdata[7];
            w_addr    = r_addr + 8'd1;
            w_rdph    = 1'b0;
            w_bitcnt  = '0;
            w_state   = ST_RD_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (w_scl_rise) begin
            w_bitcnt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_sda_oen = 1'b0;
              w_mack    = 1'b0;
              w_state   = ST_RD_ACK;
            end else begin
              w_shift   = {r_shift[6:0], 1'b0};
              w_sda_oen = ~r_shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) w_state = ST_WAIT_STOP;
            else       w_mack  = 1'b1;
          end else if (w_scl_fall && r_mack) begin
            w_state = ST_RD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oen_o = r_sda_oen;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy_o    = r_busy;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: bit-banged I2C master, registered register-file
// model, write-strobe and read-data scoreboards.
module tb_i2c_target_regif;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       sda_o, sda_oen_o, reg_we, reg_re, busy_o, irq_o;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oen_o;

  i2c_target_regif #(.TARGET_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (m_scl),
    .sda_i    (sda_bus),
    .sda_o    (sda_o),
    .sda_oen_o(sda_oen_o),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy_o   (busy_o),
    .irq_o    (irq_o)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wexp_t;

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       ack;
  } wvec_t;

  int         total = 0;
  int         bad   = 0;
  int         n_we  = 0;
  int         n_re  = 0;
  int         n_irq = 0;
  int         n_oen = 0;
  wexp_t      exp_wq[$];
  logic [7:0] exp_rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file: one-cycle read latency, data = address ^ 0x5A.
  always @(posedge clk) if (reg_re) reg_rdata <= reg_addr ^ 8'h5A;

  always @(negedge clk) begin
    wexp_t e;
    if (reg_we) begin
      n_we++;
      check("we_expected", 32'(exp_wq.size() > 0), 32'd1);
      if (exp_wq.size() > 0) begin
        e = exp_wq.pop_front();
        check("we_addr", 32'(reg_addr), 32'(e.addr));
        check("we_data", 32'(reg_wdata), 32'(e.data));
      end
    end
    if (reg_re)    n_re++;
    if (irq_o)     n_irq++;
    if (sda_oen_o) n_oen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wq();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    if (!m_scl) begin
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
    end
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_sda = b;    wq();
    m_scl = 1'b1; wq();
    s = sda_bus;  wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, s);
      d = {d[6:0], s};
    end
    m_bit(~mack, s);
  endtask

  task automatic push_we(input logic [7:0] a, input logic [7:0] d);
    wexp_t e;
    e.addr = a;
    e.data = d;
    exp_wq.push_back(e);
  endtask

  initial begin
    wvec_t      tbl[6];
    logic       a, s;
    logic [7:0] d, ep, exp_ptr;
    int         b_irq, b_we, b_re, b_oen;

    tbl[0] = '{dev: 7'h50, ptr: 8'h20, data: 8'h3C, ack: 1'b1};
    tbl[1] = '{dev: 7'h51, ptr: 8'h00, data: 8'h00, ack: 1'b0};
    tbl[2] = '{dev: 7'h00, ptr: 8'h00, data: 8'h00, ack: 1'b0};
    tbl[3] = '{dev: 7'h50, ptr: 8'hFF, data: 8'hC3, ack: 1'b1};
    tbl[4] = '{dev: 7'h28, ptr: 8'h00, data: 8'h00, ack: 1'b0};
    tbl[5] = '{dev: 7'h50, ptr: 8'h7F, data: 8'h01, ack: 1'b1};

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_oen", 32'(sda_oen_o), 32'd0);
    check("rst_we",      32'(reg_we),    32'd0);
    check("rst_re",      32'(reg_re),    32'd0);
    check("rst_busy",    32'(busy_o),    32'd0);
    check("rst_irq",     32'(irq_o),     32'd0);
    check("rst_addr",    32'(reg_addr),  32'd0);
    check("rst_wdata",   32'(reg_wdata), 32'd0);
    check("rst_sda_o",   32'(sda_o),     32'd0);
    rst = 1'b0;
    wq();
    exp_ptr = 8'h00;

    // Table: single-byte writes, address match/mismatch, general call, pointer wrap
    for (int v = 0; v < 6; v++) begin
      b_irq = n_irq; b_we = n_we;
      m_start();
      write_byte({tbl[v].dev, 1'b0}, a);
      check("t_addr_ack", 32'(a), 32'(tbl[v].ack));
      check("t_busy", 32'(busy_o), 32'(tbl[v].ack));
      if (tbl[v].ack) begin
        write_byte(tbl[v].ptr, a);
        check("t_ptr_ack", 32'(a), 32'd1);
        push_we(tbl[v].ptr, tbl[v].data);
        write_byte(tbl[v].data, a);
        check("t_data_ack", 32'(a), 32'd1);
        exp_ptr = tbl[v].ptr + 8'd1;
      end
      m_stop(); wq();
      check("t_irq",  32'(n_irq - b_irq), 32'(tbl[v].ack));
      check("t_we",   32'(n_we - b_we),   32'(tbl[v].ack));
      check("t_idle_busy", 32'(busy_o), 32'd0);
      check("t_ptr",  32'(reg_addr), 32'(exp_ptr));
    end

    // Two data bytes with auto-increment
    b_irq = n_irq; b_we = n_we;
    m_start();
    write_byte(8'hA0, a); check("w2_addr_ack", 32'(a), 32'd1);
    write_byte(8'h10, a); check("w2_ptr_ack",  32'(a), 32'd1);
    push_we(8'h10, 8'hAA);
    write_byte(8'hAA, a); check("w2_d0_ack", 32'(a), 32'd1);
    push_we(8'h11, 8'h55);
    write_byte(8'h55, a); check("w2_d1_ack", 32'(a), 32'd1);
    m_stop(); wq();
    check("w2_we_cnt", 32'(n_we - b_we),   32'd2);
    check("w2_irq",    32'(n_irq - b_irq), 32'd1);
    check("w2_ptr",    32'(reg_addr),      32'h12);

    // Read across pointer wrap after a repeated START
    b_irq = n_irq; b_re = n_re;
    m_start();
    write_byte(8'hA0, a); check("rd_waddr_ack", 32'(a), 32'd1);
    write_byte(8'hFE, a); check("rd_ptr_ack",   32'(a), 32'd1);
    m_start();
    check("sr_busy", 32'(busy_o), 32'd0);
    write_byte(8'hA1, a); check("rd_raddr_ack", 32'(a), 32'd1);
    check("rd_busy", 32'(busy_o), 32'd1);
    ep = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      exp_rq.push_back(ep ^ 8'h5A);
      ep = ep + 8'd1;
      read_byte(k < 2, d);
      check("rd_data", 32'(d), 32'(exp_rq.pop_front()));
    end
    m_stop(); wq();
    check("rd_ptr",    32'(reg_addr),      32'h01);
    check("rd_re_cnt", 32'(n_re - b_re),   32'd3);
    check("rd_irq",    32'(n_irq - b_irq), 32'd1);

    // One-clock SCL glitch before the data byte must not count as a bit
    m_start();
    write_byte(8'hA0, a); check("gl_addr_ack", 32'(a), 32'd1);
    write_byte(8'h30, a); check("gl_ptr_ack",  32'(a), 32'd1);
    m_scl = 1'b1; @(posedge clk); #1; m_scl = 1'b0;
    wq();
    push_we(8'h30, 8'h96);
    write_byte(8'h96, a); check("gl_data_ack", 32'(a), 32'd1);
    m_stop(); wq();
    check("gl_ptr", 32'(reg_addr), 32'h31);

    // START after four data bits aborts the byte; pointer retained
    b_we = n_we;
    m_start();
    write_byte(8'hA0, a); check("ab_addr_ack", 32'(a), 32'd1);
    write_byte(8'h40, a); check("ab_ptr_ack",  32'(a), 32'd1);
    m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b1, s);
    m_start();
    check("ab_no_we", 32'(n_we - b_we), 32'd0);
    check("ab_ptr_kept", 32'(reg_addr), 32'h40);
    write_byte(8'hA0, a); check("ab_readdr_ack", 32'(a), 32'd1);
    check("ab_busy", 32'(busy_o), 32'd1);
    write_byte(8'h41, a);
    push_we(8'h41, 8'h77);
    write_byte(8'h77, a); check("ab_data_ack", 32'(a), 32'd1);
    m_stop(); wq();

    // Reset while the target drives a 0 data bit
    m_start();
    write_byte(8'hA0, a);
    write_byte(8'h20, a);
    m_start();
    write_byte(8'hA1, a); check("rs_raddr_ack", 32'(a), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("rs_driving", 32'(sda_oen_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rs_released", 32'(sda_oen_o), 32'd0);
    check("rs_busy",     32'(busy_o),    32'd0);
    rst = 1'b0;
    b_irq = n_irq; b_re = n_re; b_oen = n_oen;
    read_byte(1'b0, d);
    m_stop(); wq();
    check("rs_no_drive", 32'(n_oen - b_oen), 32'd0);
    check("rs_no_re",    32'(n_re - b_re),   32'd0);
    check("rs_no_irq",   32'(n_irq - b_irq), 32'd0);

    // Recovery after reset
    m_start();
    write_byte(8'hA0, a); check("rc_addr_ack", 32'(a), 32'd1);
    write_byte(8'h05, a);
    push_we(8'h05, 8'h11);
    write_byte(8'h11, a); check("rc_data_ack", 32'(a), 32'd1);
    m_stop(); wq();

    check("we_queue_drained", 32'(exp_wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
